song_recorder: RTL

//  Inverse of song_player: samples the live key stream (key_id, key_is_pressed) while

---
 rtl/song_recorder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/song_recorder.sv
// Live key-stream recorder: quantises steady notes/rests into {duration_units, key_id}
// words, stores them in a small memory and exposes a registered read port.
module song_recorder #(
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned KEY_ID_BITS   = 4,
  parameter int unsigned DURATION_BITS = 4,
  parameter int unsigned UNIT_MS       = 100,
  parameter int unsigned SONG_DEPTH    = 32,
  localparam int unsigned W            = DURATION_BITS + KEY_ID_BITS,
  localparam int unsigned ADDR_BITS    = $clog2(SONG_DEPTH),
  localparam int unsigned CNT_BITS     = $clog2(SONG_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   record_active_level,
  input  logic [KEY_ID_BITS-1:0] key_id,
  input  logic                   key_is_pressed,
  input  logic [ADDR_BITS-1:0]   rd_addr,
  output logic [W-1:0]           rd_data,
  output logic [CNT_BITS-1:0]    entry_count,
  output logic                   is_recording,
  output logic                   wr_strobe,
  output logic                   overflow
);

  localparam int unsigned UNIT_CYCLES = UNIT_MS * (CLK_FREQ_HZ / 1000);
  localparam int unsigned MAX_UNITS   = (2 ** DURATION_BITS) - 1;
  localparam int unsigned SEG_MAX     = MAX_UNITS * UNIT_CYCLES;
  localparam int unsigned SEG_BITS    = $clog2(SEG_MAX + 1);
  localparam int unsigned HALF_UNIT   = UNIT_CYCLES / 2;

  typedef enum logic [1:0] {S_IDLE, S_RECORD, S_FLUSH} state_t;

  state_t                   state_q, state_d;
  logic                     level_q;
  logic [KEY_ID_BITS-1:0]   cur_sym_q;
  logic [SEG_BITS-1:0]      seg_len_q;
  logic [W-1:0]             mem [SONG_DEPTH];

  logic [KEY_ID_BITS-1:0]   sym_c;
  logic                     rise_c, full_c, sat_hit_c, wr_en_c;
  logic [SEG_BITS-1:0]      seg_quot_c, seg_rem_c, units_full_c;
  logic [DURATION_BITS-1:0] units_c;
  logic                     wr_req_c, take_start_c, seg_load_c, seg_clr_c, seg_inc_c;
  logic [W-1:0]             wr_word_c, rd_word_c;

  assign sym_c     = (key_is_pressed && key_id != '0) ? key_id : '0;
  assign rise_c    = record_active_level && !level_q;
  assign full_c    = (entry_count == CNT_BITS'(SONG_DEPTH));
  assign sat_hit_c = (seg_len_q == SEG_BITS'(SEG_MAX - 1));
  assign wr_en_c   = wr_req_c && !full_c;

  // Round-to-nearest unit count of the pending segment, saturated to the field width
  assign seg_quot_c   = seg_len_q / SEG_BITS'(UNIT_CYCLES);
  assign seg_rem_c    = seg_len_q % SEG_BITS'(UNIT_CYCLES);
  assign units_full_c = seg_quot_c + SEG_BITS'(seg_rem_c >= SEG_BITS'(HALF_UNIT));
  assign units_c      = (units_full_c > SEG_BITS'(MAX_UNITS)) ? DURATION_BITS'(MAX_UNITS)
                                                              : units_full_c[DURATION_BITS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (rise_c) state_d = S_RECORD;
      S_RECORD: begin
        if (wr_req_c && full_c)        state_d = S_IDLE;
        else if (!record_active_level) state_d = S_FLUSH;
      end
      S_FLUSH:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Segment bookkeeping and write requests per state
  always_comb begin
    wr_req_c     = 1'b0;
    wr_word_c    = '0;
    take_start_c = 1'b0;
    seg_load_c   = 1'b0;
    seg_clr_c    = 1'b0;
    seg_inc_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rise_c) begin
          take_start_c = 1'b1;
          seg_load_c   = 1'b1;
        end
      end
      S_RECORD: begin
        if (record_active_level) begin
          if (sym_c != cur_sym_q) begin
            seg_load_c = 1'b1;
            if (units_c != '0 && !(cur_sym_q == '0 && entry_count == '0)) begin
              wr_req_c  = 1'b1;
              wr_word_c = {units_c, cur_sym_q};
            end
          end else if (sat_hit_c) begin
            seg_clr_c = 1'b1;
            wr_req_c  = 1'b1;
            wr_word_c = {DURATION_BITS'(MAX_UNITS), cur_sym_q};
          end else begin
            seg_inc_c = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (units_c != '0 && cur_sym_q != '0) begin
          wr_req_c  = 1'b1;
          wr_word_c = {units_c, cur_sym_q};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q      <= 1'b0;
      cur_sym_q    <= '0;
      seg_len_q    <= '0;
      entry_count  <= '0;
      overflow     <= 1'b0;
      wr_strobe    <= 1'b0;
      is_recording <= 1'b0;
      rd_data      <= '0;
    end else begin
      level_q <= record_active_level;
      if (seg_load_c) begin
        cur_sym_q <= sym_c;
        seg_len_q <= SEG_BITS'(1);
      end else if (seg_clr_c) begin
        seg_len_q <= '0;
      end else if (seg_inc_c) begin
        seg_len_q <= seg_len_q + SEG_BITS'(1);
      end
      if (take_start_c) begin
        entry_count <= '0;
        overflow    <= 1'b0;
      end else begin
        if (wr_en_c)             entry_count <= entry_count + CNT_BITS'(1);
        if (wr_req_c && full_c)  overflow    <= 1'b1;
      end
      wr_strobe    <= wr_en_c;
      is_recording <= (state_d == S_RECORD);
      rd_data      <= rd_word_c;
    end
  end

  // Storage is intentionally not reset so a take survives a reset
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[entry_count[ADDR_BITS-1:0]] <= wr_word_c;
  end

  generate
    if (SONG_DEPTH == (1 << ADDR_BITS)) begin : g_rd_full
      assign rd_word_c = mem[rd_addr];
    end else begin : g_rd_part
      assign rd_word_c = (32'(rd_addr) < SONG_DEPTH) ? mem[rd_addr] : '0;
    end
  endgenerate

endmodule
